// File: rtl/req_master_if.sv
// req_master_if: command source handshake plus req/ack link to the responder.
//   cmd_valid : source offers one command
//   cmd_ready : requester can queue a command (push = cmd_valid & cmd_ready)
//   req       : level request to the responder, registered
//   ack       : one-cycle acknowledge from the responder
// Modports: master = req_master side, slave = source/responder side.
interface req_master_if;
  logic cmd_valid;
  logic cmd_ready;
  logic req;
  logic ack;

  modport master (
    input  cmd_valid,
    input  ack,
    output cmd_ready,
    output req
  );

  modport slave (
    output cmd_valid,
    output ack,
    input  cmd_ready,
    input  req
  );
endinterface

// File: rtl/req_master.sv
// req_master: queues payload-less commands and drives a level req to a
// req/ack responder. Holds req until ack or until TIMEOUT cycles pass,
// then retires the command and leaves req low for one GAP cycle.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : req_master_if.master (cmd_valid/cmd_ready, req/ack)
//   done       : one-cycle pulse, command completed by ack
//   timeout    : one-cycle pulse, command abandoned
//   spurious   : one-cycle pulse, ack seen while not requesting
//   pending    : queued commands including the active one
//   done_cnt   : completed commands, wrapping
//   err_cnt    : timeouts plus spurious acks, wrapping
module req_master #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  req_master_if.master                 bus,
  output logic                         done,
  output logic                         timeout,
  output logic                         spurious,
  output logic [$clog2(DEPTH+1)-1:0]   pending,
  output logic [CNT_W-1:0]             done_cnt,
  output logic [CNT_W-1:0]             err_cnt
);

  localparam int unsigned PEND_W = $clog2(DEPTH + 1);
  localparam int unsigned WAIT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    GAP  = 2'b10
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [WAIT_W-1:0]   wait_q;
  logic                wait_expired;
  logic                push;
  logic                pop;
  logic                done_d;
  logic                timeout_d;
  logic                spurious_d;
  logic                req_d;

  // The queue is only an occupancy counter; a pop does not free a slot
  // for a push in the same cycle because ready looks at the registered count.
  assign bus.cmd_ready = (pending < PEND_W'(DEPTH));
  assign push          = bus.cmd_valid & bus.cmd_ready;
  assign wait_expired  = (wait_q == WAIT_W'(TIMEOUT - 1));

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bus.req  <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      spurious <= 1'b0;
      pending  <= '0;
      wait_q   <= '0;
      done_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      bus.req  <= req_d;
      done     <= done_d;
      timeout  <= timeout_d;
      spurious <= spurious_d;

      // Counter restarts on every entry into REQ, advances while held.
      if (state_q == REQ && state_d == REQ)
        wait_q <= wait_q + WAIT_W'(1);
      else
        wait_q <= '0;

      case ({push, pop})
        2'b10:   pending <= pending + PEND_W'(1);
        2'b01:   pending <= pending - PEND_W'(1);
        default: pending <= pending;
      endcase

      done_cnt <= done_cnt + CNT_W'(done_d);
      err_cnt  <= err_cnt + CNT_W'(timeout_d | spurious_d);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pending != '0) state_d = REQ;
      REQ:     if (bus.ack || wait_expired) state_d = GAP;
      GAP:     state_d = (pending != '0) ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; ack beats an expiring wait counter on the same edge.
  always_comb begin
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    spurious_d = 1'b0;
    if (state_q == REQ) begin
      done_d    = bus.ack;
      timeout_d = !bus.ack && wait_expired;
    end else begin
      spurious_d = bus.ack;
    end
    pop   = done_d | timeout_d;
    req_d = (state_d == REQ);
  end

endmodule

// File: tb/tb_req_master.sv
// tb_req_master: directed bench for req_master (TIMEOUT=16, DEPTH=4,
// CNT_W=8). The bench itself plays the command source and the responder.
module tb_req_master;
  logic       clk;
  logic       rst_n;
  logic       done;
  logic       timeout;
  logic       spurious;
  logic [2:0] pending;
  logic [7:0] done_cnt;
  logic [7:0] err_cnt;

  int checks;
  int failures;

  req_master_if bus ();

  req_master #(
    .TIMEOUT (16),
    .DEPTH   (4),
    .CNT_W   (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .done     (done),
    .timeout  (timeout),
    .spurious (spurious),
    .pending  (pending),
    .done_cnt (done_cnt),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.ack       = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_req", bus.req, 0);
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_pending", pending, 0);
    check("rst_done_cnt", done_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_pulses", {done, timeout, spurious}, 0);
    rst_n = 1'b1;
    tick();

    // Single command, ack sampled at edge 4
    bus.cmd_valid = 1'b1;
    tick();                                  // edge 0
    bus.cmd_valid = 1'b0;
    check("t1_pending_e0", pending, 1);
    check("t1_req_e0", bus.req, 0);
    tick();                                  // edge 1
    check("t1_req_e1", bus.req, 1);
    tick();                                  // edge 2
    tick();                                  // edge 3
    check("t1_req_e3", bus.req, 1);
    bus.ack = 1'b1;
    tick();                                  // edge 4
    bus.ack = 1'b0;
    check("t1_req_e4", bus.req, 0);
    check("t1_done_e4", done, 1);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_pending_e4", pending, 0);
    check("t1_err_cnt", err_cnt, 0);
    tick();                                  // edge 5, GAP -> IDLE
    check("t1_done_e5", done, 0);
    check("t1_req_e5", bus.req, 0);

    // Two back-to-back commands
    bus.cmd_valid = 1'b1;
    tick();                                  // edge 0
    tick();                                  // edge 1
    bus.cmd_valid = 1'b0;
    check("t2_req_e1", bus.req, 1);
    check("t2_pending_e1", pending, 2);
    tick();                                  // edge 2
    tick();                                  // edge 3
    bus.ack = 1'b1;
    tick();                                  // edge 4
    bus.ack = 1'b0;
    check("t2_req_e4", bus.req, 0);
    check("t2_done_e4", done, 1);
    check("t2_pending_e4", pending, 1);
    tick();                                  // edge 5
    check("t2_req_e5", bus.req, 1);
    check("t2_done_e5", done, 0);
    tick();                                  // edge 6
    tick();                                  // edge 7
    bus.ack = 1'b1;
    tick();                                  // edge 8
    bus.ack = 1'b0;
    check("t2_done_e8", done, 1);
    check("t2_req_e8", bus.req, 0);
    check("t2_done_cnt", done_cnt, 3);
    check("t2_err_cnt", err_cnt, 0);
    check("t2_pending_e8", pending, 0);
    tick();                                  // GAP -> IDLE

    // Timeout: req held exactly 16 cycles
    bus.cmd_valid = 1'b1;
    tick();                                  // edge 0
    bus.cmd_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();                                // edge i
      check($sformatf("t3_req_e%0d", i), bus.req, 1);
      check($sformatf("t3_tmo_e%0d", i), timeout, 0);
    end
    tick();                                  // edge 17
    check("t3_req_e17", bus.req, 0);
    check("t3_timeout_e17", timeout, 1);
    check("t3_done_e17", done, 0);
    check("t3_err_cnt", err_cnt, 1);
    check("t3_done_cnt", done_cnt, 3);
    check("t3_pending", pending, 0);
    tick();
    check("t3_timeout_clr", timeout, 0);

    // Race: ack on the edge where the wait counter reaches 15
    bus.cmd_valid = 1'b1;
    tick();                                  // edge 0
    bus.cmd_valid = 1'b0;
    for (int i = 1; i <= 16; i++) tick();    // edges 1..16
    check("t4_req_e16", bus.req, 1);
    bus.ack = 1'b1;
    tick();                                  // edge 17
    bus.ack = 1'b0;
    check("t4_done", done, 1);
    check("t4_timeout", timeout, 0);
    check("t4_err_cnt", err_cnt, 1);
    check("t4_done_cnt", done_cnt, 4);
    tick();                                  // GAP -> IDLE

    // FIFO full with ack held off
    bus.cmd_valid = 1'b1;
    tick();                                  // edge 0
    check("t5_pending_e0", pending, 1);
    tick();                                  // edge 1
    check("t5_pending_e1", pending, 2);
    tick();                                  // edge 2
    check("t5_pending_e2", pending, 3);
    check("t5_ready_e2", bus.cmd_ready, 1);
    tick();                                  // edge 3
    check("t5_pending_e3", pending, 4);
    check("t5_ready_e3", bus.cmd_ready, 0);
    tick();                                  // edge 4
    tick();                                  // edge 5
    check("t5_pending_e5", pending, 4);
    check("t5_ready_e5", bus.cmd_ready, 0);
    // Pop while full: the push offered on the same edge is refused
    bus.ack = 1'b1;
    tick();                                  // edge 6
    bus.ack = 1'b0;
    check("t5_done_e6", done, 1);
    check("t5_pending_e6", pending, 3);
    check("t5_ready_e6", bus.cmd_ready, 1);
    tick();                                  // edge 7, push accepted, GAP -> REQ
    bus.cmd_valid = 1'b0;
    check("t5_pending_e7", pending, 4);
    check("t5_req_e7", bus.req, 1);
    bus.ack = 1'b1;
    tick();                                  // edge 8
    bus.ack = 1'b0;
    check("t5_pending_e8", pending, 3);
    tick();                                  // edge 9, REQ
    check("t5_req_e9", bus.req, 1);
    // Push and pop on the same edge
    bus.cmd_valid = 1'b1;
    bus.ack       = 1'b1;
    tick();                                  // edge 10
    bus.cmd_valid = 1'b0;
    bus.ack       = 1'b0;
    check("t5_pushpop_pending", pending, 3);
    check("t5_pushpop_done", done, 1);
    for (int i = 0; i < 3; i++) begin
      tick();                                // GAP -> REQ
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
    end
    check("t5_drained", pending, 0);
    check("t5_done_cnt", done_cnt, 10);
    check("t5_err_cnt", err_cnt, 1);
    tick();                                  // GAP -> IDLE

    // Reset mid-REQ
    bus.cmd_valid = 1'b1;
    tick();
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    check("t6_req_before", bus.req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_req_async", bus.req, 0);
    check("t6_pending", pending, 0);
    check("t6_done_cnt", done_cnt, 0);
    check("t6_err_cnt", err_cnt, 0);
    check("t6_ready", bus.cmd_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("t6_req_after", bus.req, 0);

    // Spurious ack in IDLE
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("t7_spurious", spurious, 1);
    check("t7_err_cnt", err_cnt, 1);
    check("t7_req", bus.req, 0);
    tick();
    check("t7_spurious_clr", spurious, 0);

    // Counter wrap: 256 completions
    for (int i = 0; i < 256; i++) begin
      bus.cmd_valid = 1'b1;
      tick();                                // push
      bus.cmd_valid = 1'b0;
      tick();                                // IDLE -> REQ
      bus.ack = 1'b1;
      tick();                                // done
      bus.ack = 1'b0;
      tick();                                // GAP -> IDLE
      if (i == 254) check("t8_done_cnt_255", done_cnt, 255);
    end
    check("t8_done_cnt_wrap", done_cnt, 0);
    check("t8_err_cnt", err_cnt, 1);
    check("t8_pending", pending, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
